// File: rtl/riscie_pkg.sv
// ============================================================================
// Module  : riscie_pkg
// Brief   : Shared constants and types for the riscie fetch front end:
//           bubble instruction, fetch FSM encoding and the IF/ID bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscie_pkg;

    // Datapath width carried in the IF/ID bundle.
    localparam int unsigned c_XLEN = 32;

    // addi x0,x0,0 - architectural no-op used as the IF/ID bubble.
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic              valid;
        logic [31:0]       instr;
        logic [c_XLEN-1:0] pc;
    } ifid_t;

    // A flushed IF/ID entry: invalid, no-op, address kept for debug visibility.
    function automatic ifid_t ifid_bubble(input logic [c_XLEN-1:0] pc);
        ifid_t b;
        b.valid = 1'b0;
        b.instr = c_NOP_INSTR;
        b.pc    = pc;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// Module  : if_skid_buf
// Brief   : One-entry skid buffer holding an {instr, pc} pair that arrived
//           while decode was stalled. Clear has priority over load, load
//           over unload.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_skid_buf
    import riscie_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_clear,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_full,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_full;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;

    // Occupancy flag and stored word; the payload is only written on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_instr <= c_NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : Instruction-fetch controller. Issues single-outstanding requests
//           at the PC address, captures returned words into IF/ID, parks one
//           word in a skid buffer across decode stalls and flushes on a taken
//           branch.
//           Optional build macro FETCH_TIMEOUT_EN adds a request watchdog and
//           the sticky fetch_err output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_ctrl
    import riscie_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              branch_taken,
    input  logic              id_stall,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              pc_hold,
    output logic              pc_src,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              fetch_err
`endif
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    ifid_t             r_ifid;

    logic              w_flush;
    logic              w_capture;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic              w_skid_full;
    logic [31:0]       w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;
    logic              w_parked;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned          c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0]   c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_err;
    logic               w_timeout;

    // Wait counter: runs only while a request sits unanswered in REQ.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_REQ) || mem_ready) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Sticky error flag; once set the controller stays parked until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign fetch_err = r_err;
    assign w_parked  = r_err;
`else
    assign w_parked  = 1'b0;
`endif

    // The PC mux follows the resolved branch directly; the address is the PC.
    assign pc_src   = branch_taken;
    assign mem_addr = pc_addr;
    assign w_flush  = branch_taken && !w_parked && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; a taken branch overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        mem_req       = 1'b0;
        pc_hold       = 1'b1;
        w_capture     = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_timeout     = 1'b0;
`endif
        if (reset || w_parked) begin
            w_state_nxt = ST_IDLE;
        end else if (branch_taken) begin
            pc_hold     = 1'b0;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        pc_hold = 1'b0;
                        if (id_stall) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_capture   = 1'b1;
                        end
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        if (r_wait_cnt == c_TO_LAST) begin
                            w_timeout   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    if (!w_skid_full) begin
                        w_state_nxt = ST_REQ;
                    end else if (!id_stall) begin
                        w_skid_unload = 1'b1;
                        w_state_nxt   = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // IF/ID register: flush beats a fresh memory word, which beats the skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid <= ifid_bubble('0);
        end else if (w_flush) begin
            r_ifid <= ifid_bubble(r_ifid.pc);
        end else if (w_capture) begin
            r_ifid <= {1'b1, mem_rdata, c_XLEN'(pc_addr)};
        end else if (w_skid_unload) begin
            r_ifid <= {1'b1, w_skid_instr, c_XLEN'(w_skid_pc)};
        end
    end

    if_skid_buf #(
        .ADDR_W   (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_flush),
        .i_instr  (mem_rdata),
        .i_pc     (pc_addr),
        .o_full   (w_skid_full),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    assign ifid_valid = r_ifid.valid;
    assign ifid_instr = (r_ifid.valid) ? r_ifid.instr : NOP_INSTR;
    assign ifid_pc    = ADDR_W'(r_ifid.pc);

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// Module  : tb_if_fetch_ctrl
// Brief   : Cycle-trace bench for if_fetch_ctrl. Each table row is one clock
//           cycle of inputs plus the outputs expected in that cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [31:0] c_A = 32'hA000_0001, c_B = 32'hB000_0002,
                            c_C = 32'hC000_0003, c_D = 32'hD000_0004,
                            c_E = 32'hE000_0005, c_W = 32'h5EED_0006,
                            c_F = 32'hF000_0007, c_G = 32'h0BAD_0008,
                            c_H = 32'h1100_0009, c_J = 32'h0BAD_000A,
                            c_K = 32'h0BAD_000B, c_L = 32'h2200_000C,
                            c_M = 32'h0BAD_000D, c_N = 32'h3300_000E,
                            c_X = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        branch_taken, id_stall, mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req, pc_hold, pc_src, ifid_valid;
    logic [31:0] mem_addr, ifid_instr, ifid_pc;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pc_addr      (pc_addr),
        .branch_taken (branch_taken),
        .id_stall     (id_stall),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .pc_hold      (pc_hold),
        .pc_src       (pc_src),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err    (fetch_err)
`endif
    );

    typedef struct {
        logic        rst, br, st, mr;
        logic [31:0] pc, rd;
        logic        e_req, e_hold, e_src, e_v;
        logic [31:0] e_addr, e_instr, e_ipc;
    } vec_t;

    localparam int c_NV = 27;
    vec_t vecs [c_NV];

    function automatic vec_t mk(input logic rst, input logic [31:0] pc,
                                input logic br, input logic st, input logic mr,
                                input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_hold, input logic e_src,
                                input logic e_v, input logic [31:0] e_instr,
                                input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst; v.pc = pc; v.br = br; v.st = st; v.mr = mr; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_hold = e_hold;
        v.e_src = e_src; v.e_v = e_v; v.e_instr = e_instr; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] pc, input logic br,
                         input logic st, input logic mr, input logic [31:0] rd);
        reset = rst; pc_addr = pc; branch_taken = br;
        id_stall = st; mem_ready = mr; mem_rdata = rd;
    endtask

    initial begin
        //            rst pc        br st mr rd   | req addr      hold src v instr ipc
        vecs[0]  = mk(1, 32'h000, 0, 0, 1, c_A,  0, 32'h000, 1, 0, 0, c_NOP, 32'h000);
        vecs[1]  = mk(0, 32'h000, 0, 0, 1, c_A,  0, 32'h000, 1, 0, 0, c_NOP, 32'h000);
        vecs[2]  = mk(0, 32'h000, 0, 0, 1, c_A,  1, 32'h000, 0, 0, 0, c_NOP, 32'h000);
        vecs[3]  = mk(0, 32'h004, 0, 0, 1, c_B,  1, 32'h004, 0, 0, 1, c_A,   32'h000);
        vecs[4]  = mk(0, 32'h008, 0, 0, 1, c_C,  1, 32'h008, 0, 0, 1, c_B,   32'h004);
        vecs[5]  = mk(0, 32'h00C, 0, 0, 1, c_D,  1, 32'h00C, 0, 0, 1, c_C,   32'h008);
        // memory wait states at 0x10
        vecs[6]  = mk(0, 32'h010, 0, 0, 0, c_X,  1, 32'h010, 1, 0, 1, c_D,   32'h00C);
        vecs[7]  = mk(0, 32'h010, 0, 0, 0, c_X,  1, 32'h010, 1, 0, 1, c_D,   32'h00C);
        vecs[8]  = mk(0, 32'h010, 0, 0, 0, c_X,  1, 32'h010, 1, 0, 1, c_D,   32'h00C);
        vecs[9]  = mk(0, 32'h010, 0, 0, 1, c_E,  1, 32'h010, 0, 0, 1, c_D,   32'h00C);
        // decode stall while W returns -> skid, HOLD
        vecs[10] = mk(0, 32'h014, 0, 1, 1, c_W,  1, 32'h014, 0, 0, 1, c_E,   32'h010);
        vecs[11] = mk(0, 32'h018, 0, 1, 0, c_X,  0, 32'h018, 1, 0, 1, c_E,   32'h010);
        vecs[12] = mk(0, 32'h018, 0, 0, 0, c_X,  0, 32'h018, 1, 0, 1, c_E,   32'h010);
        vecs[13] = mk(0, 32'h018, 0, 0, 1, c_F,  1, 32'h018, 0, 0, 1, c_W,   32'h014);
        // branch during pending fetch, target 0x100
        vecs[14] = mk(0, 32'h01C, 0, 0, 0, c_X,  1, 32'h01C, 1, 0, 1, c_F,   32'h018);
        vecs[15] = mk(0, 32'h01C, 1, 0, 0, c_G,  0, 32'h01C, 0, 1, 1, c_F,   32'h018);
        vecs[16] = mk(0, 32'h100, 0, 0, 1, c_G,  0, 32'h100, 1, 0, 0, c_NOP, 32'h018);
        vecs[17] = mk(0, 32'h100, 0, 0, 1, c_H,  1, 32'h100, 0, 0, 0, c_NOP, 32'h018);
        // branch with full skid and id_stall high
        vecs[18] = mk(0, 32'h104, 0, 1, 1, c_J,  1, 32'h104, 0, 0, 1, c_H,   32'h100);
        vecs[19] = mk(0, 32'h108, 1, 1, 1, c_K,  0, 32'h108, 0, 1, 1, c_H,   32'h100);
        vecs[20] = mk(0, 32'h200, 0, 0, 0, c_X,  0, 32'h200, 1, 0, 0, c_NOP, 32'h100);
        vecs[21] = mk(0, 32'h200, 0, 0, 0, c_X,  1, 32'h200, 1, 0, 0, c_NOP, 32'h100);
        vecs[22] = mk(0, 32'h200, 0, 0, 1, c_L,  1, 32'h200, 0, 0, 0, c_NOP, 32'h100);
        // stall with nothing arriving: IF/ID holds
        vecs[23] = mk(0, 32'h204, 0, 0, 0, c_X,  1, 32'h204, 1, 0, 1, c_L,   32'h200);
        vecs[24] = mk(0, 32'h204, 0, 1, 0, c_X,  1, 32'h204, 1, 0, 1, c_L,   32'h200);
        // reset overrides a concurrent branch and ready word
        vecs[25] = mk(1, 32'h204, 1, 0, 1, c_M,  0, 32'h204, 1, 1, 1, c_L,   32'h200);
        vecs[26] = mk(0, 32'h000, 0, 0, 0, c_X,  0, 32'h000, 1, 0, 0, c_NOP, 32'h000);

        drive(1, 32'h0, 0, 0, 0, c_X);
        repeat (2) @(posedge clk);

        for (int i = 0; i < c_NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].st, vecs[i].mr, vecs[i].rd);
            #1;
            check("mem_req",    i, {31'd0, mem_req},    {31'd0, vecs[i].e_req});
            check("mem_addr",   i, mem_addr,            vecs[i].e_addr);
            check("pc_hold",    i, {31'd0, pc_hold},    {31'd0, vecs[i].e_hold});
            check("pc_src",     i, {31'd0, pc_src},     {31'd0, vecs[i].e_src});
            check("ifid_valid", i, {31'd0, ifid_valid}, {31'd0, vecs[i].e_v});
            check("ifid_instr", i, ifid_instr,          vecs[i].e_instr);
            check("ifid_pc",    i, ifid_pc,             vecs[i].e_ipc);
        end

        // The last table row left the FSM in IDLE; it is now in REQ at 0x300.
`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive(0, 32'h300, 0, 0, 0, c_X);
            #1;
            check("to_wait_req", k, {31'd0, mem_req},   32'd1);
            check("to_wait_err", k, {31'd0, fetch_err}, 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 32'h300, k[0], 0, 1, c_N);
            #1;
            check("to_park_req",  k, {31'd0, mem_req},   32'd0);
            check("to_park_hold", k, {31'd0, pc_hold},   32'd1);
            check("to_park_err",  k, {31'd0, fetch_err}, 32'd1);
        end
        @(negedge clk);
        drive(1, 32'h0, 0, 0, 0, c_X);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 0, c_X);
        #1;
        check("to_reset_err", 0, {31'd0, fetch_err}, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(0, 32'h300, 0, 0, 0, c_X);
            #1;
            check("wait_req",  k, {31'd0, mem_req}, 32'd1);
            check("wait_hold", k, {31'd0, pc_hold}, 32'd1);
            check("wait_addr", k, mem_addr,         32'h300);
        end
        @(negedge clk);
        drive(0, 32'h300, 0, 0, 1, c_N);
        #1;
        check("late_hold", 0, {31'd0, pc_hold}, 32'd0);
        @(negedge clk);
        drive(0, 32'h304, 0, 0, 0, c_X);
        #1;
        check("late_valid", 0, {31'd0, ifid_valid}, 32'd1);
        check("late_instr", 0, ifid_instr,          c_N);
        check("late_pc",    0, ifid_pc,             32'h300);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
